// File: rtl/smpl_pkg.sv
// Shared types for the triggered sample source: sample width, trigger modes
// and the frame state machine encoding.
package smpl_pkg;

  localparam int SMPL_W = 10;

  typedef enum logic [1:0] {
    TrigAuto   = 2'd0,
    TrigNormal = 2'd1,
    TrigFree   = 2'd2
  } trig_mode_t;

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Arm    = 2'd1,
    Wait   = 2'd2,
    Stream = 2'd3
  } state_t;

  // Code 3 has no mode of its own and behaves as free-run.
  function automatic logic is_free_run(input logic [1:0] mode);
    return (mode != TrigAuto) && (mode != TrigNormal);
  endfunction

endpackage

// File: rtl/smpl_trig_source_if.sv
// Consumer-facing handshake of the sample source: frame request in,
// samples with valid strobe and trigger status out.
interface smpl_trig_source_if;
  import smpl_pkg::*;

  logic              smpl_req;
  logic [SMPL_W-1:0] smpl;
  logic              smpl_valid;
  logic              triggered;

  modport master (
    input  smpl_req,
    output smpl,
    output smpl_valid,
    output triggered
  );

  modport slave (
    output smpl_req,
    input  smpl,
    input  smpl_valid,
    input  triggered
  );

endinterface

// File: rtl/trig_detect.sv
// Combinational level-crossing compare between two consecutive decimated
// samples; all compares are unsigned.
module trig_detect
  import smpl_pkg::*;
(
  input  logic [SMPL_W-1:0] prev,
  input  logic [SMPL_W-1:0] cur,
  input  logic [SMPL_W-1:0] level,
  input  logic              fall,
  output logic              hit
);

  always_comb begin
    hit = 1'b0;
    if (fall)
      hit = (prev > level) && (cur <= level);
    else
      hit = (prev < level) && (cur >= level);
  end

endmodule

// File: rtl/smpl_trig_source.sv
// Decimating, level-triggered sample source: arms on request, discards a
// holdoff of samples, waits for a trigger, then streams decimated samples.
module smpl_trig_source
  import smpl_pkg::*;
#(
  parameter int          HOLDOFF = 4,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic              clkSmpl,
  input  logic              n_reset,
  input  logic [SMPL_W-1:0] adc,
  input  logic [SMPL_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [1:0]        trig_mode,
  input  logic [7:0]        decim,
  smpl_trig_source_if.master bus
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF);

  state_t            state, state_next;
  logic [SMPL_W-1:0] a0, cur, prev, cur_next, prev_next, level_l;
  logic [7:0]        dec_cnt, decim_l, hold_cnt;
  logic [15:0]       to_cnt;
  logic [1:0]        mode_l;
  logic              edge_l;
  logic              strobe, hit_raw, hit;
  logic              start_arm, go_wait, go_stream, stream_trig;

  // Trigger evaluation sees the pair as it will be after this strobe's shift.
  always_comb begin
    strobe    = (dec_cnt == 8'd0);
    cur_next  = strobe ? a0  : cur;
    prev_next = strobe ? cur : prev;
    hit       = strobe && hit_raw;
  end

  trig_detect u_detect (
    .prev  (prev_next),
    .cur   (cur_next),
    .level (level_l),
    .fall  (edge_l),
    .hit   (hit_raw)
  );

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset)
      state <= Idle;
    else
      state <= state_next;
  end

  // Dropping the request wins over every other transition.
  always_comb begin
    state_next  = state;
    start_arm   = 1'b0;
    go_wait     = 1'b0;
    go_stream   = 1'b0;
    stream_trig = 1'b0;
    if (!bus.smpl_req) begin
      state_next = Idle;
    end else begin
      case (state)
        Idle: begin
          state_next = Arm;
          start_arm  = 1'b1;
        end
        Arm: begin
          if (strobe && (hold_cnt <= 8'd1)) begin
            state_next = Wait;
            go_wait    = 1'b1;
          end
        end
        Wait: begin
          if (is_free_run(mode_l)) begin
            go_stream = strobe;
          end else if (hit) begin
            go_stream   = 1'b1;
            stream_trig = 1'b1;
          end else if ((mode_l == TrigAuto) && strobe && (to_cnt == TIMEOUT)) begin
            go_stream = 1'b1;
          end
          if (go_stream)
            state_next = Stream;
        end
        Stream: state_next = Stream;
        default: state_next = Idle;
      endcase
    end
  end

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) begin
      a0       <= '0;
      cur      <= '0;
      prev     <= '0;
      dec_cnt  <= '0;
      decim_l  <= '0;
      level_l  <= '0;
      edge_l   <= 1'b0;
      mode_l   <= 2'd0;
      hold_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      a0   <= adc;
      cur  <= cur_next;
      prev <= prev_next;
      if (start_arm || (dec_cnt >= decim_l))
        dec_cnt <= 8'd0;
      else
        dec_cnt <= dec_cnt + 8'd1;
      if (start_arm) begin
        decim_l  <= decim;
        level_l  <= trig_level;
        edge_l   <= trig_edge;
        mode_l   <= trig_mode;
        hold_cnt <= HOLD_INIT;
      end else if ((state == Arm) && strobe && (hold_cnt != 8'd0)) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
      // Timeout saturates so auto mode fires on the first strobe after it.
      if (go_wait)
        to_cnt <= 16'd0;
      else if ((state == Wait) && (to_cnt != TIMEOUT))
        to_cnt <= to_cnt + 16'd1;
    end
  end

  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) begin
      bus.smpl       <= '0;
      bus.smpl_valid <= 1'b0;
      bus.triggered  <= 1'b0;
    end else begin
      bus.smpl       <= cur_next;
      bus.smpl_valid <= strobe && (state_next == Stream);
      if (start_arm)
        bus.triggered <= 1'b0;
      else if (go_stream)
        bus.triggered <= stream_trig;
    end
  end

endmodule

// File: doc/smpl_trig_source.md
SMPL_TRIG_SOURCE -- requirements
Module: smpl_trig_source

Interface
REQ-001 SHALL have parameter HOLDOFF, default 4, number of decimated samples discarded after arming (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 16'hFFFF, clkSmpl cycles spent in Wait before auto-trigger fires.
REQ-003 SHALL have port clkSmpl  input  1  sample clock; all logic in this single domain.
REQ-004 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port adc  input  10  raw ADC code, new value every clkSmpl cycle.
REQ-006 SHALL have port trig_level  input  10  unsigned trigger threshold.
REQ-007 SHALL have port trig_edge  input  1  0 = rising, 1 = falling.
REQ-008 SHALL have port trig_mode  input  2  0 = auto, 1 = normal, 2 = free-run, 3 = treated as free-run.
REQ-009 SHALL have port decim  input  8  keep 1 of every decim+1 samples.
REQ-010 SHALL have port smpl_req  input  1  frame request from the sample consumer; high = keep supplying samples.
REQ-011 SHALL have port smpl  output  10  sample to consumer.
REQ-012 SHALL have port smpl_valid  output  1  smpl is a new sample this cycle; the consumer writes only when smpl_valid is high.
REQ-013 SHALL have port triggered  output  1  status: current frame started on a real crossing (0 = auto or free-run start).

Function
REQ-014 SHALL register adc once (a0) before any use; all further references are to a0.
REQ-015 SHALL run a decimation counter 0..decim_l; strobe = counter==0; counter cleared to 0 on Idle->Arm.
REQ-016 SHALL latch decim, trig_level, trig_edge and trig_mode into *_l registers on Idle->Arm; input changes mid-frame SHALL have no effect.
REQ-017 SHALL on each strobe shift cur <= a0 and prev <= cur (decimated sample pair).
REQ-018 SHALL detect a crossing when strobe is high and prev/cur satisfy the crossing rule; trigger evaluation uses the new cur and the new prev.
REQ-019 SHALL use the rising crossing rule prev < level && cur >= level.
REQ-020 SHALL use the falling crossing rule prev > level && cur <= level.
REQ-021 SHALL perform all crossing compares as unsigned 10-bit.
REQ-022 SHALL use FSM states Idle, Arm, Wait, Stream.
REQ-023 SHALL transition Idle->Arm when smpl_req=1, loading holdoff counter = HOLDOFF.
REQ-024 SHALL in Arm decrement the holdoff counter per strobe, and transition Arm->Wait when it reaches 0.
REQ-025 SHALL transition Wait->Stream on the first strobe when trig_mode_l is free-run; triggered <= 0.
REQ-026 SHALL transition Wait->Stream on a crossing; triggered <= 1.
REQ-027 SHALL transition Wait->Stream in auto mode when the 16-bit timeout counter (cleared on Arm->Wait) reaches TIMEOUT, then wait for the next strobe; triggered <= 0.
REQ-028 SHALL in normal mode wait indefinitely with no timeout.
REQ-029 SHALL return any state -> Idle when smpl_req=0, taking priority over every other transition.
REQ-030 SHALL register smpl <= cur and smpl_valid <= strobe && (state==Stream || entering Stream this cycle).
REQ-031 SHALL make the first valid sample the crossing sample, presented 1 cycle after the detecting strobe.
REQ-032 SHALL hold smpl_valid = 0 in Idle, Arm and Wait.
REQ-033 SHALL use a valid-to-valid spacing of exactly decim_l+1 cycles; decim_l=0 gives smpl_valid continuously high.
REQ-034 SHALL hold triggered until the next Idle->Arm, which clears it to 0.
REQ-035 SHALL on simultaneous smpl_req fall and crossing in Wait go to Idle, with smpl_valid = 0.

Reset
REQ-036 SHALL on n_reset low force state=Idle, smpl=0, smpl_valid=0, triggered=0, and clear all counters, prev, cur and a0 to 0, asynchronously.
REQ-037 SHALL apply reset mid-frame identically; after release, behaviour SHALL resume from Idle per REQ-023.

Structure
REQ-038 SHALL place SMPL_W=10, trig_mode_t {TrigAuto, TrigNormal, TrigFree} and the FSM state enum in package smpl_pkg.
REQ-039 SHALL put the crossing compare (prev, cur, level, edge -> hit) in sub-module trig_detect (combinational); the FSM, counters and output registers stay in the top module.

Verification
REQ-040 SHALL cover: normal mode, rising, level=512, decim=0, ramp adc 500..530 step 1, smpl_req=1 -> first smpl_valid with smpl=512, triggered=1, then 513, 514 on consecutive cycles.
REQ-041 SHALL cover: falling edge, level=100, adc square wave 200/50, decim=3 -> first smpl=50, smpl_valid every 4th cycle.
REQ-042 SHALL cover: auto mode, TIMEOUT=20, constant adc=300 -> Stream entered after HOLDOFF strobes + 20 cycles + next strobe, triggered=0, smpl=300.
REQ-043 SHALL cover: normal mode, constant adc, 10000 cycles -> smpl_valid never asserts.
REQ-044 SHALL cover: smpl_req dropped mid-Stream, then n_reset pulsed during a later Wait -> smpl_valid=0 the cycle after the drop; all outputs 0 during reset; a new frame after reset triggers correctly.
REQ-045 SHALL cover: decim or level changed mid-Stream -> valid spacing and trigger behaviour unchanged until the next frame.
